// File: rtl/tc_register_bank.sv
// tc_register_bank: DEPTH x BIT_WIDTH register set with one save (write)
// port and two independent registered load (read) ports. Optional
// write-through bypass on reads and an optional hard-wired zero entry 0.
module tc_register_bank #(
    parameter int BIT_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int DEPTH       = 8,
    parameter int WRITE_FIRST = 1,
    parameter int ZERO_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  save,
    input  logic [ADDR_WIDTH-1:0] save_addr,
    input  logic [BIT_WIDTH-1:0]  in,
    input  logic                  load_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    output logic [BIT_WIDTH-1:0]  out_a,
    input  logic                  load_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [BIT_WIDTH-1:0]  out_b
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    // An address is "live" when it names an implemented entry that is not
    // the hard-wired zero entry. Saves and reads to dead addresses are
    // dropped / return zero respectively.
    function automatic logic addr_live(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < DEPTH_LIM) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic                 save_hit;
    logic [BIT_WIDTH-1:0] rd_a;
    logic [BIT_WIDTH-1:0] rd_b;
    logic [BIT_WIDTH-1:0] nxt_a;
    logic [BIT_WIDTH-1:0] nxt_b;

    assign save_hit = save && addr_live(save_addr);

    // Entry storage: cleared by reset, written on an effective save.
    // NOTE: the array is a bank of flops, not a RAM macro, so it is reset
    // like any other state; a RAM would need an explicit clearing sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (save_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking so every flop samples pre-edge values;
                // blocking here would let later logic see this edge's write.
                if (save_addr == ADDR_WIDTH'(i)) begin
                    mem[i] <= in;
                end
            end
        end
    end

    // Pre-edge entry lookup for both ports; unmatched addresses yield zero.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_a == ADDR_WIDTH'(i)) rd_a = mem[i];
            if (addr_b == ADDR_WIDTH'(i)) rd_b = mem[i];
        end
    end

    // Per-port read selection: disabled/dead address -> 0, bypass, or entry.
    always_comb begin
        nxt_a = '0;
        nxt_b = '0;
        if (load_a && addr_live(addr_a)) begin
            if ((WRITE_FIRST != 0) && save_hit && (save_addr == addr_a)) nxt_a = in;
            else                                                         nxt_a = rd_a;
        end
        if (load_b && addr_live(addr_b)) begin
            if ((WRITE_FIRST != 0) && save_hit && (save_addr == addr_b)) nxt_b = in;
            else                                                         nxt_b = rd_b;
        end
    end

    // Registered read outputs; hold 0 throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a <= '0;
            out_b <= '0;
        end else begin
            out_a <= nxt_a;
            out_b <= nxt_b;
        end
    end

endmodule

// File: tb/tb_tc_register_bank.sv
// Testbench for tc_register_bank. Three instances with different
// configurations share one stimulus stream:
//   0: DEPTH 8, WRITE_FIRST 1, ZERO_REG 0
//   1: DEPTH 5, WRITE_FIRST 0, ZERO_REG 1
//   2: DEPTH 8, WRITE_FIRST 1, ZERO_REG 1
// A behavioural model predicts each edge's outputs into a queue; a monitor
// pops and compares on the falling edge.
module tb_tc_register_bank;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       save;
    logic [2:0] save_addr;
    logic [7:0] din;
    logic       load_a;
    logic [2:0] addr_a;
    logic       load_b;
    logic [2:0] addr_b;
    logic [7:0] out_a [N];
    logic [7:0] out_b [N];

    always #5 clk = ~clk;

    tc_register_bank #(.BIT_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(8), .WRITE_FIRST(1), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .in(din),
        .load_a(load_a), .addr_a(addr_a), .out_a(out_a[0]),
        .load_b(load_b), .addr_b(addr_b), .out_b(out_b[0]));

    tc_register_bank #(.BIT_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(5), .WRITE_FIRST(0), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .in(din),
        .load_a(load_a), .addr_a(addr_a), .out_a(out_a[1]),
        .load_b(load_b), .addr_b(addr_b), .out_b(out_b[1]));

    tc_register_bank #(.BIT_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(8), .WRITE_FIRST(1), .ZERO_REG(1)) u_dut2 (
        .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .in(din),
        .load_a(load_a), .addr_a(addr_a), .out_a(out_a[2]),
        .load_b(load_b), .addr_b(addr_b), .out_b(out_b[2]));

    // ---------------- reference model ----------------
    int cfg_depth [N] = '{8, 5, 8};
    int cfg_wf    [N] = '{1, 0, 1};
    int cfg_zr    [N] = '{0, 1, 1};

    logic [7:0] model_mem [N][8];

    typedef struct {
        logic [N-1:0][7:0] a;
        logic [N-1:0][7:0] b;
        int                edge_no;
    } exp_t;

    exp_t exp_q [$];

    int checks   = 0;
    int failures = 0;
    int pushes   = 0;
    int pops     = 0;
    int edge_cnt = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    function automatic logic live(input int d, input logic [2:0] addr);
        return (int'(addr) < cfg_depth[d]) && !(cfg_zr[d] != 0 && addr == 3'd0);
    endfunction

    function automatic logic [7:0] model_read(input int d, input logic ld, input logic [2:0] addr);
        if (!ld || !live(d, addr)) return 8'h00;
        if (cfg_wf[d] != 0 && save && live(d, save_addr) && save_addr == addr) return din;
        return model_mem[d][addr];
    endfunction

    // Called right after a rising edge: predict that edge's outputs.
    task automatic model_step();
        exp_t e;
        edge_cnt++;
        e.edge_no = edge_cnt;
        for (int d = 0; d < N; d++) begin
            if (rst) begin
                e.a[d] = 8'h00;
                e.b[d] = 8'h00;
                for (int k = 0; k < 8; k++) model_mem[d][k] = 8'h00;
            end else begin
                e.a[d] = model_read(d, load_a, addr_a);
                e.b[d] = model_read(d, load_b, addr_b);
                if (save && live(d, save_addr)) model_mem[d][save_addr] = din;
            end
        end
        exp_q.push_back(e);
        pushes++;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            for (int d = 0; d < N; d++) begin
                check($sformatf("edge%0d_dut%0d_out_a", e.edge_no, d), out_a[d], e.a[d]);
                check($sformatf("edge%0d_dut%0d_out_b", e.edge_no, d), out_b[d], e.b[d]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic [2:0] sa, input logic [7:0] d,
                         input logic la, input logic [2:0] aa, input logic lb, input logic [2:0] ab);
        save = s; save_addr = sa; din = d;
        load_a = la; addr_a = aa; load_b = lb; addr_b = ab;
    endtask

    task automatic cycle(input logic s, input logic [2:0] sa, input logic [7:0] d,
                         input logic la, input logic [2:0] aa, input logic lb, input logic [2:0] ab);
        @(negedge clk);
        drive(s, sa, d, la, aa, lb, ab);
        @(posedge clk);
        model_step();
    endtask

    task automatic drive_random();
        logic [2:0] sa;
        sa = 3'($urandom_range(0, 7));
        drive(1'($urandom), sa, 8'($urandom),
              1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0) ? sa : 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0) ? sa : 3'($urandom_range(0, 7)));
    endtask

    // Assert rst between edges, check outputs clear at once, hold, release.
    task automatic pulse_reset(input int hold, input logic rand_inputs);
        @(negedge clk);
        if (rand_inputs) drive_random();
        else             drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        for (int d = 0; d < N; d++) begin
            check($sformatf("async_rst_dut%0d_out_a", d), out_a[d], 8'h00);
            check($sformatf("async_rst_dut%0d_out_b", d), out_b[d], 8'h00);
        end
        @(posedge clk);
        model_step();
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            drive_random();
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        drive_random();
        #($urandom_range(1, 3));
        rst = 1'b0;
        @(posedge clk);
        model_step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "simulation did not terminate");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int d = 0; d < N; d++)
            for (int k = 0; k < 8; k++) model_mem[d][k] = 8'h00;
        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check($sformatf("reset_state_dut%0d_out_a", d), out_a[d], 8'h00);
            check($sformatf("reset_state_dut%0d_out_b", d), out_b[d], 8'h00);
        end
        rst = 1'b0;

        // Fill with 0xAA, read back, then reset and read everything again.
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 8'hAA, 1'b0, 3'd0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
        pulse_reset(1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(i));

        // Write then read, then disabled read returns zero.
        cycle(1'b1, 3'd3, 8'h5C, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 1'b0, 3'd0);

        // Bypass versus old data on a same-edge save.
        cycle(1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 1'b1, 3'd2);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2);

        // Out-of-range save and read.
        cycle(1'b1, 3'd6, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd6);
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'd6);

        // Zero entry: save then read, then same-edge save and read.
        cycle(1'b1, 3'd0, 8'h7E, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
        cycle(1'b1, 3'd0, 8'h7E, 1'b1, 3'd0, 1'b1, 3'd0);
        cycle(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset(int'($urandom_range(1, 3)), 1'b1);
            end else begin
                @(negedge clk);
                drive_random();
                @(posedge clk);
                model_step();
            end
        end

        cycle(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        #1;
        checks++;
        if (pops != pushes || exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=%0d", pops, pushes);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
